// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running VGA raster timing generator (default 640x480 @ 60 Hz).
//   Produces the pixel/line counters, sync pulses, the visible-area flag and
//   line/frame strobes for the downstream pixel/colour stage. Every output is
//   registered and derived from the same next coordinate, so all outputs
//   describe the same (hpos, vpos) on every cycle.
//
//   Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//     defined   -> frame counter register drives frame_no
//     undefined -> no frame counter, frame_no tied to 0
//
// Ports
//   clk          in   pixel clock
//   reset        in   async assert, active-high (release synchronously upstream)
//   hsync        out  horizontal sync, active level set by SYNC_NEG
//   vsync        out  vertical sync (level per line), active level set by SYNC_NEG
//   display_on   out  1 inside the visible area
//   hpos         out  [9:0] pixel column, 0..H_TOTAL-1
//   vpos         out  [9:0] line number, 0..V_TOTAL-1
//   line_start   out  1-cycle strobe at hpos==0
//   frame_start  out  1-cycle strobe at hpos==0 && vpos==0
//   frame_no     out  [FRAME_W-1:0] frame counter
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_NEG = 1'b1,
    parameter int FRAME_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [9:0]         hpos,
    output logic [9:0]         vpos,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_no
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds are 11 bits so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_END  = 11'(V_VIS);
    localparam logic [10:0] HS_BEG     = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG     = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_VIS + V_FP + V_SYNC);

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    logic [10:0] h_ext, v_ext;
    logic        hs_act, vs_act;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (hpos_q == H_LAST) begin
            hpos_d = '0;
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
        end

        // All outputs are decoded from the coordinate being entered, so they
        // land in the same register stage as hpos/vpos.
        h_ext  = {1'b0, hpos_d};
        v_ext  = {1'b0, vpos_d};
        hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);

        hsync_d       = hs_act ^ SYNC_NEG;
        vsync_d       = vs_act ^ SYNC_NEG;
        display_on_d  = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
        line_start_d  = (hpos_d == '0);
        frame_start_d = (hpos_d == '0) && (vpos_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q        <= H_LAST;
            vpos_q        <= V_LAST;
            hsync_q       <= SYNC_NEG;
            vsync_q       <= SYNC_NEG;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_no_q, frame_no_d;

    // Resets to all ones so the first frame entered after reset reads 0.
    always_comb begin
        frame_no_d = frame_no_q;
        if (frame_start_d) frame_no_d = frame_no_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_no_q <= '1;
        else       frame_no_q <= frame_no_d;
    end

    assign frame_no = frame_no_q;
`else
    assign frame_no = '0;
`endif

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen using a shrunken raster so whole frames
//   and the frame-counter wrap fit in a short run:
//     H: VIS=16 FP=2 SYNC=4 BP=3  -> H_TOTAL=25, hsync active for hpos 18..21
//     V: VIS=8  FP=2 SYNC=2 BP=3  -> V_TOTAL=15, vsync active for vpos 10..11
//     frame = 375 cycles, FRAME_W=3 (wraps 7 -> 0)
//   Two instances share clk/reset: dut_n (active-low syncs), dut_p (active-high).
//   The driver pushes the expected outputs per cycle; the monitor pops them on
//   the falling edge and also checks per-line/per-frame totals.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct {
        int h;
        int v;
        int de;
        int ls;
        int fs;
        int hs_act;
        int vs_act;
        int fn;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       hs_n, vs_n, de_n, ls_n, fs_n;
    logic [9:0] h_n, v_n;
    logic [2:0] fn_n;
    logic       hs_p, vs_p, de_p, ls_p, fs_p;
    logic [9:0] h_p, v_p;
    logic [2:0] fn_p;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // model state
    int m_h, m_v, m_f;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_NEG(1'b1), .FRAME_W(3)
    ) dut_n (
        .clk(clk), .reset(rst), .hsync(hs_n), .vsync(vs_n), .display_on(de_n),
        .hpos(h_n), .vpos(v_n), .line_start(ls_n), .frame_start(fs_n), .frame_no(fn_n)
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_NEG(1'b0), .FRAME_W(3)
    ) dut_p (
        .clk(clk), .reset(rst), .hsync(hs_p), .vsync(vs_p), .display_on(de_p),
        .hpos(h_p), .vpos(v_p), .line_start(ls_p), .frame_start(fs_p), .frame_no(fn_p)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t make_exp(input bit in_rst);
        exp_t e;
        if (in_rst) begin
            e.h = 24; e.v = 14; e.de = 0; e.ls = 0; e.fs = 0;
            e.hs_act = 0; e.vs_act = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            e.fn = 7;
`else
            e.fn = 0;
`endif
        end else begin
            e.h      = m_h;
            e.v      = m_v;
            e.de     = (m_h < 16 && m_v < 8) ? 1 : 0;
            e.ls     = (m_h == 0) ? 1 : 0;
            e.fs     = (m_h == 0 && m_v == 0) ? 1 : 0;
            e.hs_act = (m_h >= 18 && m_h <= 21) ? 1 : 0;
            e.vs_act = (m_v >= 10 && m_v <= 11) ? 1 : 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
            e.fn = m_f;
`else
            e.fn = 0;
`endif
        end
        return e;
    endfunction

    task automatic model_reset();
        m_h = 24; m_v = 14; m_f = 7;
    endtask

    task automatic model_step();
        if (m_h == 24) begin
            m_h = 0;
            m_v = (m_v == 14) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
        if (m_h == 0 && m_v == 0) m_f = (m_f + 1) % 8;
    endtask

    // One clock: advance the model per the reset level seen at the edge, push expectation.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        exp_q.push_back(make_exp(rst));
    endtask

    // Reset asserted between edges; outputs must go to reset state before the next edge.
    task automatic async_reset_cycle();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        exp_q.push_back(make_exp(1'b1));
    endtask

    task automatic release_reset();
        #6;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 1'b1;
        repeat (3) tick();
        release_reset();

        // Nine frames: covers line/frame wraps, sync windows and frame_no 7 -> 0.
        repeat (9 * 375 + 10) tick();

        // Run to (12,5) then reset asynchronously mid-frame.
        for (int i = 0; i < 400; i++) begin
            tick();
            if (m_h == 12 && m_v == 5) break;
        end
        check("reach_12_5", (m_h == 12 && m_v == 5) ? 1 : 0, 1);
        async_reset_cycle();
        repeat (2) tick();
        release_reset();
        repeat (60) tick();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- monitor ----------------
    int  line_hs, frame_cyc, frame_vs, frame_de;
    bit  line_valid = 1'b0, frame_valid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hpos",        int'(h_n),  e.h);
            check("vpos",        int'(v_n),  e.v);
            check("display_on",  int'(de_n), e.de);
            check("line_start",  int'(ls_n), e.ls);
            check("frame_start", int'(fs_n), e.fs);
            check("hsync_n",     int'(hs_n), 1 - e.hs_act);
            check("vsync_n",     int'(vs_n), 1 - e.vs_act);
            check("frame_no",    int'(fn_n), e.fn);
            check("hsync_p",     int'(hs_p), e.hs_act);
            check("vsync_p",     int'(vs_p), e.vs_act);
            check("hpos_p",      int'(h_p),  e.h);
        end

        if (rst) begin
            line_valid  = 1'b0;
            frame_valid = 1'b0;
        end else begin
            if (ls_n) begin
                if (line_valid) check("hsync_cycles_per_line", line_hs, 4);
                line_hs    = 0;
                line_valid = 1'b1;
            end
            if (fs_n) begin
                if (frame_valid) begin
                    check("frame_period", frame_cyc, 375);
                    check("vsync_cycles_per_frame", frame_vs, 50);
                    check("display_cycles_per_frame", frame_de, 128);
                end
                frame_cyc   = 0;
                frame_vs    = 0;
                frame_de    = 0;
                frame_valid = 1'b1;
            end
            line_hs   += (hs_n == 1'b0) ? 1 : 0;
            frame_cyc += 1;
            frame_vs  += (vs_n == 1'b0) ? 1 : 0;
            frame_de  += de_n ? 1 : 0;
        end
    end

endmodule
